// File: rtl/pipe_mem_arbiter_if.sv
// Bundle of the IF-stage, MEM-stage and memory-port signals of pipe_mem_arbiter.
// Signal suffixes are taken from the arbiter's point of view (_i drives into it,
// _o comes out of it).
//   slave  : the arbiter itself
//   master : the pipeline plus memory that surround it
// Ports: none (parameters ADDR_W, DATA_W size the address and data buses).
interface pipe_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_data_o;

  // Data load/store requester
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;

  // Shared single-port memory
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Pipeline freeze controls
  logic              stall_if_o;
  logic              stall_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_ack_o, if_data_o,
    output dm_ack_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_ack_o, if_data_o,
    input  dm_ack_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_mem_o
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter
// Shares one single-port, fixed-latency memory between the instruction fetch
// (IF) and data access (MEM) stages of the pipeline. Conflicts are resolved
// round-robin against the last served requester. Each access strobes mem_en_o
// for one cycle, waits MEM_LAT cycles for read data and returns a one-cycle ack
// to the owner. Only one transaction is ever in flight.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high (aborts any access in flight)
//   bus    : pipe_mem_arbiter_if.slave - request/ack handshakes for IF and
//            MEM, memory port, and the combinational stall_if_o/stall_mem_o
// Parameters:
//   ADDR_W, DATA_W : bus widths
//   MEM_LAT        : cycles from mem_en_o to valid mem_rdata_i, 1..15
module pipe_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic [3:0]        cnt_q;

  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              req_any;
  logic              grant_dm_d;

  // Arbitration: a lone requester wins; on a conflict the requester that was
  // not served last wins.
  always_comb begin
    req_any    = bus.if_req_i | bus.dm_req_i;
    grant_dm_d = 1'b0;
    if (bus.if_req_i && bus.dm_req_i) begin
      grant_dm_d = (last_owner_q == OWN_IF);
    end else begin
      grant_dm_d = bus.dm_req_i;
    end
  end

  // mem_en_o is registered, so it is raised on the IDLE->ISSUE edge and
  // therefore reads high for exactly the ISSUE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_data_q    <= '0;
      dm_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      mem_en_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            if (grant_dm_d) begin
              owner_q     <= OWN_DM;
              mem_addr_q  <= bus.dm_addr_i;
              mem_we_q    <= bus.dm_we_i;
              mem_wdata_q <= bus.dm_wdata_i;
            end else begin
              owner_q     <= OWN_IF;
              mem_addr_q  <= bus.if_addr_i;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
            mem_en_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_q   <= 4'd1;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (cnt_q == LAT) begin
            if (owner_q == OWN_IF) begin
              if_data_q <= bus.mem_rdata_i;
              if_ack_q  <= 1'b1;
            end else begin
              // A store completes without touching the load data register.
              if (!mem_we_q) begin
                dm_rdata_q <= bus.mem_rdata_i;
              end
              dm_ack_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        ST_RESP: begin
          last_owner_q <= owner_q;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  assign bus.stall_if_o  = bus.if_req_i & ~if_ack_q;
  assign bus.stall_mem_o = bus.dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed testbench for pipe_mem_arbiter: one instance with MEM_LAT=2 and one
// with MEM_LAT=1, each behind a simple fixed-latency memory model.
module tb_pipe_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] SENT = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  pipe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  pipe_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  pipe_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8C01_0004;
      32'h14:  return 32'h0022_1820;
      32'h30:  return 32'h1111_2222;
      32'h40:  return 32'hA5A5_0040;
      32'h44:  return 32'h2042_0001;
      default: return {a[15:0], 16'h5A5A};
    endcase
  endfunction

  // Memory models: read data appears exactly MEM_LAT cycles after the strobe,
  // a sentinel is driven in every other cycle.
  logic [31:0] a_s0 = SENT, a_s1 = SENT, b_s0 = SENT;
  always @(posedge clk) begin
    a_s0 <= (bus_a.mem_en_o && !bus_a.mem_we_o) ? mem_word(bus_a.mem_addr_o) : SENT;
    a_s1 <= a_s0;
    b_s0 <= (bus_b.mem_en_o && !bus_b.mem_we_o) ? mem_word(bus_b.mem_addr_o) : SENT;
  end
  assign bus_a.mem_rdata_i = a_s1;
  assign bus_b.mem_rdata_i = b_s0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Single IF fetch on dut_a starting at the current negedge (cycle 0).
  task automatic fetch_a(input string tag, input logic [31:0] addr);
    bus_a.if_req_i  = 1'b1;
    bus_a.if_addr_i = addr;
    for (int c = 0; c <= 4; c++) begin
      #1;
      check_eq($sformatf("%s stall_if c%0d", tag, c), bus_a.stall_if_o, (c < 4));
      check_eq($sformatf("%s mem_en c%0d", tag, c), bus_a.mem_en_o, (c == 1));
      check_eq($sformatf("%s if_ack c%0d", tag, c), bus_a.if_ack_o, (c == 4));
      if (c == 1) begin
        check_eq({tag, " mem_we"}, bus_a.mem_we_o, 1'b0);
        check_eq({tag, " mem_addr"}, bus_a.mem_addr_o, addr);
      end
      if (c == 4) begin
        check_eq({tag, " if_data"}, bus_a.if_data_o, mem_word(addr));
        bus_a.if_req_i = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    bus_a.if_req_i = 1'b0; bus_a.if_addr_i = '0;
    bus_a.dm_req_i = 1'b0; bus_a.dm_we_i = 1'b0; bus_a.dm_addr_i = '0; bus_a.dm_wdata_i = '0;
    bus_b.if_req_i = 1'b0; bus_b.if_addr_i = '0;
    bus_b.dm_req_i = 1'b0; bus_b.dm_we_i = 1'b0; bus_b.dm_addr_i = '0; bus_b.dm_wdata_i = '0;

    // Reset state
    repeat (2) step();
    #1;
    check_eq("rst if_ack", bus_a.if_ack_o, 1'b0);
    check_eq("rst dm_ack", bus_a.dm_ack_o, 1'b0);
    check_eq("rst mem_en", bus_a.mem_en_o, 1'b0);
    check_eq("rst mem_addr", bus_a.mem_addr_o, 32'h0);
    check_eq("rst if_data", bus_a.if_data_o, 32'h0);
    check_eq("rst dm_rdata", bus_a.dm_rdata_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Basic fetch, MEM_LAT=2
    fetch_a("t2", 32'h10);

    // Reset while idle clears registered outputs asynchronously
    #1 rst = 1'b1;
    #1;
    check_eq("t1a if_data", bus_a.if_data_o, 32'h0);
    check_eq("t1a mem_addr", bus_a.mem_addr_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Reset during WAIT aborts; no late ack, no replay
    bus_a.if_req_i  = 1'b1;
    bus_a.if_addr_i = 32'h14;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check_eq("t1b mem_addr", bus_a.mem_addr_o, 32'h0);
    check_eq("t1b mem_en", bus_a.mem_en_o, 1'b0);
    bus_a.if_req_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("t1b no_ack c%0d", c), bus_a.if_ack_o, 1'b0);
      check_eq($sformatf("t1b no_en c%0d", c), bus_a.mem_en_o, 1'b0);
      step();
    end
    fetch_a("t1c", 32'h14);

    // Conflict right after reset: DM first, then IF
    reset_pulse();
    bus_a.if_req_i  = 1'b1; bus_a.if_addr_i = 32'h14;
    bus_a.dm_req_i  = 1'b1; bus_a.dm_we_i   = 1'b0; bus_a.dm_addr_i = 32'h30;
    for (int c = 0; c <= 9; c++) begin
      #1;
      check_eq($sformatf("t4 stall_if c%0d", c), bus_a.stall_if_o, (c <= 8));
      check_eq($sformatf("t4 stall_mem c%0d", c), bus_a.stall_mem_o, (c < 4));
      check_eq($sformatf("t4 mem_en c%0d", c), bus_a.mem_en_o, (c == 1 || c == 6));
      check_eq($sformatf("t4 dm_ack c%0d", c), bus_a.dm_ack_o, (c == 4));
      check_eq($sformatf("t4 if_ack c%0d", c), bus_a.if_ack_o, (c == 9));
      if (c == 1) check_eq("t4 addr dm", bus_a.mem_addr_o, 32'h30);
      if (c == 6) check_eq("t4 addr if", bus_a.mem_addr_o, 32'h14);
      if (c == 4) begin
        check_eq("t4 dm_rdata", bus_a.dm_rdata_o, 32'h1111_2222);
        bus_a.dm_req_i = 1'b0;
      end
      if (c == 9) begin
        check_eq("t4 if_data", bus_a.if_data_o, 32'h0022_1820);
        bus_a.if_req_i = 1'b0;
      end
      step();
    end

    // Store: load data register untouched, IF never acked
    bus_a.dm_req_i = 1'b1; bus_a.dm_we_i = 1'b1;
    bus_a.dm_addr_i = 32'h20; bus_a.dm_wdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c <= 4; c++) begin
      #1;
      check_eq($sformatf("t3 mem_en c%0d", c), bus_a.mem_en_o, (c == 1));
      check_eq($sformatf("t3 dm_ack c%0d", c), bus_a.dm_ack_o, (c == 4));
      check_eq($sformatf("t3 if_ack c%0d", c), bus_a.if_ack_o, 1'b0);
      if (c == 1) begin
        check_eq("t3 mem_we", bus_a.mem_we_o, 1'b1);
        check_eq("t3 mem_addr", bus_a.mem_addr_o, 32'h20);
        check_eq("t3 mem_wdata", bus_a.mem_wdata_o, 32'hDEAD_BEEF);
      end
      if (c == 3) check_eq("t3 addr stable", bus_a.mem_addr_o, 32'h20);
      if (c == 4) begin
        check_eq("t3 dm_rdata kept", bus_a.dm_rdata_o, 32'h1111_2222);
        bus_a.dm_req_i = 1'b0;
        bus_a.dm_we_i  = 1'b0;
      end
      step();
    end

    // Both held continuously: DM, IF, DM, IF with acks every 5 cycles
    reset_pulse();
    begin
      logic prev_en;
      prev_en = 1'b0;
      bus_a.if_req_i = 1'b1; bus_a.if_addr_i = 32'h44;
      bus_a.dm_req_i = 1'b1; bus_a.dm_addr_i = 32'h40;
      for (int c = 0; c <= 21; c++) begin
        #1;
        check_eq($sformatf("t5 en_adjacent c%0d", c), prev_en & bus_a.mem_en_o, 1'b0);
        check_eq($sformatf("t5 dm_ack c%0d", c), bus_a.dm_ack_o, (c == 4 || c == 14));
        check_eq($sformatf("t5 if_ack c%0d", c), bus_a.if_ack_o, (c == 9 || c == 19));
        if (c == 4 || c == 14) check_eq($sformatf("t5 dm_rdata c%0d", c), bus_a.dm_rdata_o, 32'hA5A5_0040);
        if (c == 9 || c == 19) check_eq($sformatf("t5 if_data c%0d", c), bus_a.if_data_o, 32'h2042_0001);
        prev_en = bus_a.mem_en_o;
        if (c == 19) begin
          bus_a.if_req_i = 1'b0;
          bus_a.dm_req_i = 1'b0;
        end
        step();
      end
    end

    // MEM_LAT=1 fetch on dut_b
    bus_b.if_req_i  = 1'b1;
    bus_b.if_addr_i = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      #1;
      check_eq($sformatf("t6 mem_en c%0d", c), bus_b.mem_en_o, (c == 1));
      check_eq($sformatf("t6 if_ack c%0d", c), bus_b.if_ack_o, (c == 3));
      check_eq($sformatf("t6 stall_if c%0d", c), bus_b.stall_if_o, (c < 3));
      if (c == 3) begin
        check_eq("t6 if_data", bus_b.if_data_o, 32'h8C01_0004);
        bus_b.if_req_i = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
Sequences one shared single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined CPU. The block arbitrates between the two requesters and drives the memory port through a small FSM. It returns read data with a one-cycle ack pulse and provides stall outputs that the pipeline uses to freeze PC, IF/ID and EX/MEM while an access is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory latency: cycles from the mem_en_o cycle to the cycle mem_rdata_i is valid (legal range 1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
if_req_i  in  1  fetch request; held until if_ack_o
if_addr_i  in  ADDR_W  fetch address; stable while if_req_i=1
if_ack_o  out  1  one-cycle completion pulse for fetch
if_data_o  out  DATA_W  fetched instruction; valid when if_ack_o=1
dm_req_i  in  1  data request; held until dm_ack_o
dm_we_i  in  1  1=store, 0=load
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_ack_o  out  1  one-cycle completion pulse for data access
dm_rdata_o  out  DATA_W  load data; valid when dm_ack_o=1
mem_en_o  out  1  memory access strobe, exactly one cycle per transaction
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en_o
stall_if_o  out  1  = if_req_i & ~if_ack_o (combinational)
stall_mem_o  out  1  = dm_req_i & ~dm_ack_o (combinational)

Behaviour:
- Reset (async, rst_i=1): state=IDLE. All registered outputs 0: acks, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o. cnt=0. last_owner=IF.
- A reset asserted mid-transaction aborts it immediately. No ack is issued and the transaction is never replayed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only one request pending: grant that requester.
  - Both pending: grant the requester not equal to last_owner (round-robin). After reset, a first conflict therefore goes to DM.
  - On grant: latch owner, addr, we (forced 0 for IF), wdata; go to ISSUE.
- ISSUE (1 cycle): mem_en_o=1, mem_we_o, mem_addr_o and mem_wdata_o from the latched values. Set cnt=1, go to WAIT.
- WAIT: hold mem_en_o=0 and keep the address/data outputs stable.
  - When cnt==MEM_LAT: capture mem_rdata_i into the owner's data register, go to RESP.
  - Otherwise increment cnt.
- RESP (1 cycle): owner's ack_o=1. Set last_owner=owner, go to IDLE.
- RESP never grants directly, so there is at least one IDLE cycle between transactions.
- Latency (MEM_LAT=L): request first seen in IDLE at cycle t → mem_en_o at t+1 → data valid at t+1+L → ack at t+L+2.
- Stores use the same timing. The ack marks write completion; the data register is not updated on a store.
- Non-owner data register holds its previous value. The ack of the non-owner stays 0.
- Requester rules: req, addr, we and wdata must be held until ack. If req drops early, the transaction still completes and ack still pulses (no abort).
- req still high in the cycle after ack is treated as a new request.
- mem_en_o is never asserted in two consecutive cycles. At most one transaction is outstanding.
- cnt width is 4 bits. MEM_LAT outside 1..15 is illegal.

Test Plan:
1. Assert rst_i while idle, then during WAIT → all outputs 0 asynchronously, no ack after release. A request at the next IDLE is serviced normally.
2. MEM_LAT=2, if_req_i at cycle 0 with if_addr_i=0x10, memory returns 0x8C010004 in cycle 3 → mem_en_o=1, mem_we_o=0, mem_addr_o=0x10 in cycle 1. if_ack_o=1 with if_data_o=0x8C010004 in cycle 4. stall_if_o=1 in cycles 0–3 and 0 in cycle 4.
3. Store: dm_req_i=1, dm_we_i=1, dm_addr_i=0x20, dm_wdata_i=0xDEADBEEF at cycle 0 → mem_en_o=mem_we_o=1, addr 0x20, wdata 0xDEADBEEF in cycle 1. dm_ack_o in cycle 4. dm_rdata_o unchanged, if_ack_o stays 0.
4. Both requests at cycle 0 after reset → DM is served first (mem_en_o cycle 1, dm_ack_o cycle 4). IF is granted in IDLE cycle 5 (mem_en_o cycle 6, if_ack_o cycle 9). stall_if_o=1 for cycles 0–8.
5. Both requests held continuously for 4 transactions → grant order DM, IF, DM, IF. Ack pulses every 5 cycles. mem_en_o is never high in adjacent cycles.
6. MEM_LAT=1, single IF fetch at cycle 0 → mem_en_o in cycle 1, mem_rdata_i sampled in cycle 2, if_ack_o in cycle 3.
